// File: rtl/spi_sram_bus_if.sv
// rtl/spi_sram_bus_if.sv - cpu memory bus bundle between cpu (master) and spi_sram_bus (slave)
interface spi_sram_bus_if;
    logic [15:0] bus_address;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_read;
    logic        bus_write;
    logic        bus_wait;

    modport master (
        output bus_address, bus_wdata, bus_read, bus_write,
        input  bus_rdata, bus_wait
    );

    modport slave (
        input  bus_address, bus_wdata, bus_read, bus_write,
        output bus_rdata, bus_wait
    );
endinterface

// File: rtl/spi_sram_bus.sv
// rtl/spi_sram_bus.sv - cpu bus responder running one 32-bit SPI frame per byte access to a 23LC512-style SRAM
module spi_sram_bus #(
    parameter int unsigned SCK_HALF  = 1,
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter logic [7:0]  CMD_WRITE = 8'h02
) (
    input  logic           clk,
    input  logic           rst,
    spi_sram_bus_if.slave  bus,
    output logic           spi_cs_n,
    output logic           spi_sck,
    output logic           spi_mosi,
    input  logic           spi_miso
);
    typedef enum logic [2:0] {IDLE, START, SHIFT, FINISH, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(SCK_HALF - 1);

    state_t      state;
    logic [31:0] tx;
    logic [7:0]  rx;
    logic [4:0]  bit_cnt;
    logic [7:0]  div;
    logic        is_write;
    logic [7:0]  rdata;
    logic        req;
    logic [31:0] frame;

    assign req           = bus.bus_read | bus.bus_write;
    assign bus.bus_wait  = req & (state != DONE);
    assign bus.bus_rdata = rdata;

    // A simultaneous read+write request is serviced as a write.
    assign frame = bus.bus_write ? {CMD_WRITE, bus.bus_address, bus.bus_wdata}
                                 : {CMD_READ,  bus.bus_address, 8'h00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
            rdata    <= 8'h00;
            bit_cnt  <= 5'd0;
            div      <= 8'd0;
            tx       <= 32'd0;
            rx       <= 8'd0;
            is_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        is_write <= bus.bus_write;
                        tx       <= frame;
                        spi_cs_n <= 1'b0;
                        spi_mosi <= frame[31];
                        bit_cnt  <= 5'd0;
                        div      <= 8'd0;
                        state    <= START;
                    end
                end
                START: state <= SHIFT;
                SHIFT: begin
                    if (div == DIV_LAST) begin
                        div <= 8'd0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            rx      <= {rx[6:0], spi_miso};
                        end else begin
                            spi_sck  <= 1'b0;
                            tx       <= {tx[30:0], 1'b0};
                            spi_mosi <= tx[30];
                            bit_cnt  <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd31)
                                state <= FINISH;
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                FINISH: begin
                    spi_cs_n <= 1'b1;
                    spi_mosi <= 1'b0;
                    // Only the final byte of the frame carries SRAM read data.
                    if (!is_write)
                        rdata <= rx;
                    state <= DONE;
                end
                DONE: begin
                    if (!req)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sram_bus.sv
// tb/tb_spi_sram_bus.sv - scoreboard bench for spi_sram_bus with a behavioural 23LC512 model
module tb_spi_sram_bus;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_sram_bus_if b ();
    spi_sram_bus_if b3 ();
    logic cs_n, sck, mosi, miso;
    logic cs_n3, sck3, mosi3;
    logic miso3 = 1'b1;

    spi_sram_bus #(.SCK_HALF(1)) dut (
        .clk(clk), .rst(rst), .bus(b.slave),
        .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi), .spi_miso(miso)
    );
    spi_sram_bus #(.SCK_HALF(3)) dut3 (
        .clk(clk), .rst(rst), .bus(b3.slave),
        .spi_cs_n(cs_n3), .spi_sck(sck3), .spi_mosi(mosi3), .spi_miso(miso3)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // SRAM model
    logic [7:0]  mem [0:65535];
    logic [31:0] sh;
    int          cnt = 0;
    logic [7:0]  rd_op = 8'h00;
    logic [15:0] rd_addr = 16'h0000;
    int          sck_outside = 0;

    always @(negedge cs_n) begin
        cnt   = 0;
        sh    = 32'd0;
        rd_op = 8'h00;
    end

    always @(posedge sck) begin
        if (cs_n) sck_outside++;
        sh = {sh[30:0], mosi};
        cnt++;
        if (cnt == 24) begin
            rd_op   = sh[23:16];
            rd_addr = sh[15:0];
        end
        if (cnt == 32 && sh[31:24] == 8'h02) mem[sh[23:8]] = sh[7:0];
    end

    assign miso = (cnt >= 24 && cnt < 32 && rd_op == 8'h03) ? mem[rd_addr][5'(31 - cnt)] : 1'b0;

    // Frame scoreboard
    logic [31:0] exp_frames [$];
    logic [7:0]  exp_rdata [$];
    bit mon_en = 1'b0;
    bit skip_frame = 1'b0;
    int frames_seen = 0;

    always @(posedge cs_n) begin
        if (mon_en) begin
            if (skip_frame) begin
                skip_frame = 1'b0;
            end else begin
                frames_seen++;
                chk("frame_sck_count", cnt, 32);
                if (exp_frames.size() == 0) chk("frame_unexpected", sh, 32'hFFFF_FFFF);
                else chk("frame_mosi", sh, exp_frames.pop_front());
            end
        end
    end

    // SCK level durations on the SCK_HALF=3 instance
    int run3 = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0, hi_cnt = 0;
    logic prev3 = 1'b0;
    bit seen_hi3 = 1'b0;
    always @(negedge clk) begin
        if (cs_n3 !== 1'b0) begin
            run3 = 0; prev3 = 1'b0; seen_hi3 = 1'b0;
        end else if (sck3 != prev3) begin
            if (prev3) begin
                hi_cnt++;
                if (run3 < hi_min) hi_min = run3;
                if (run3 > hi_max) hi_max = run3;
            end else if (seen_hi3) begin
                if (run3 < lo_min) lo_min = run3;
                if (run3 > lo_max) lo_max = run3;
            end
            if (sck3) seen_hi3 = 1'b1;
            prev3 = sck3;
            run3  = 1;
        end else begin
            run3++;
        end
    end

    task automatic access(input bit sel, input logic [15:0] a, input logic [7:0] d,
                          input bit wr, input int exp_lat, input string tag);
        int  cyc;
        bit  found;
        logic w, c;
        @(posedge clk); #1;
        if (sel) begin
            b3.bus_address = a; b3.bus_wdata = d; b3.bus_write = wr; b3.bus_read = !wr;
        end else begin
            b.bus_address = a; b.bus_wdata = d; b.bus_write = wr; b.bus_read = !wr;
        end
        found = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            w = sel ? b3.bus_wait : b.bus_wait;
            c = sel ? cs_n3 : cs_n;
            if (i == 0) begin
                chk({tag, "_wait_c0"}, w, 1'b1);
                chk({tag, "_csn_c0"}, c, 1'b1);
            end
            if (i == 1) chk({tag, "_csn_c1"}, c, 1'b0);
            if (!w) begin
                found = 1'b1;
                cyc   = i;
                break;
            end
        end
        chk({tag, "_done_seen"}, found, 1'b1);
        chk({tag, "_latency"}, cyc, exp_lat);
        if (!sel) chk({tag, "_rdata"}, b.bus_rdata, exp_rdata.pop_front());
        @(posedge clk); #1;
        if (sel) begin b3.bus_read = 1'b0; b3.bus_write = 1'b0; end
        else begin b.bus_read = 1'b0; b.bus_write = 1'b0; end
    endtask

    initial begin
        int  bad;
        bit  found;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8));
        mem[16'h1234] = 8'hA5;
        mem[16'h0001] = 8'h3C;
        b.bus_address = '0; b.bus_wdata = '0; b.bus_read = 1'b0; b.bus_write = 1'b0;
        b3.bus_address = '0; b3.bus_wdata = '0; b3.bus_read = 1'b0; b3.bus_write = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_csn", cs_n, 1'b1);
        chk("rst_sck", sck, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_rdata", b.bus_rdata, 8'h00);
        chk("rst_wait", b.bus_wait, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        exp_frames.push_back(32'h0312_3400); exp_rdata.push_back(8'hA5);
        access(0, 16'h1234, 8'h00, 0, 67, "rd1234");

        exp_frames.push_back(32'h02BE_EF5A); exp_rdata.push_back(8'hA5);
        access(0, 16'hBEEF, 8'h5A, 1, 67, "wrBEEF");
        chk("mem_BEEF", mem[16'hBEEF], 8'h5A);

        exp_frames.push_back(32'h0200_1077); exp_rdata.push_back(8'hA5);
        access(0, 16'h0010, 8'h77, 1, 67, "wr0010");
        exp_frames.push_back(32'h0300_1000); exp_rdata.push_back(8'h77);
        access(0, 16'h0010, 8'h00, 0, 67, "rd0010");

        access(1, 16'h00FF, 8'h00, 0, 195, "h3_rd00FF");
        chk("h3_rdata", b3.bus_rdata, 8'hFF);
        chk("h3_hi_min", hi_min, 3);
        chk("h3_hi_max", hi_max, 3);
        chk("h3_lo_min", lo_min, 3);
        chk("h3_lo_max", lo_max, 3);
        chk("h3_hi_cnt", hi_cnt, 32);

        // Reset at the 10th SCK rising edge
        skip_frame = 1'b1;
        @(posedge clk); #1;
        b.bus_address = 16'h1234; b.bus_read = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cnt == 10) begin found = 1'b1; break; end
        end
        chk("rst_mid_reached", found, 1'b1);
        rst = 1'b1; b.bus_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_csn", cs_n, 1'b1);
        chk("rst_mid_sck", sck, 1'b0);
        chk("rst_mid_rdata", b.bus_rdata, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_frames.push_back(32'h0300_0100); exp_rdata.push_back(8'h3C);
        access(0, 16'h0001, 8'h00, 0, 67, "rd0001");

        // Request dropped mid-transaction
        exp_frames.push_back(32'h0312_3400);
        @(posedge clk); #1;
        b.bus_address = 16'h1234; b.bus_read = 1'b1;
        repeat (20) @(posedge clk);
        #1 b.bus_read = 1'b0;
        bad = 0; found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b.bus_wait !== 1'b0) bad++;
            if (cs_n) begin found = 1'b1; break; end
        end
        chk("drop_frame_end", found, 1'b1);
        chk("drop_wait_low", bad, 0);
        chk("drop_rdata", b.bus_rdata, 8'hA5);
        exp_frames.push_back(32'h0300_1000); exp_rdata.push_back(8'h77);
        access(0, 16'h0010, 8'h00, 0, 67, "after_drop");

        repeat (4) @(posedge clk);
        chk("sck_outside_cs", sck_outside, 0);
        chk("frames_pending", exp_frames.size(), 0);
        chk("frames_seen", frames_seen, 7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/spi_sram_bus.md
Name: spi_sram_bus

Overview:
- Bus responder for the cpu memory bus: services cpu byte reads/writes by running one SPI transaction per access on an external 23LC512-style SPI SRAM.
- Holds bus_wait high until the transaction completes.
- Sits between the cpu and the chip's SPI pins, occupying the full 64 KiB address space.

Parameters:
SCK_HALF, 1, SCK half-period in clk cycles; legal range 1..255
CMD_READ, 8'h03, SPI read opcode
CMD_WRITE, 8'h02, SPI write opcode

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
bus_address  input  16  access address; connects to cpu bus_address_out
bus_wdata  input  8  write data; connects to cpu bus_data_out
bus_rdata  output  8  read data; connects to cpu bus_data_in
bus_read  input  1  read request level
bus_write  input  1  write request level
bus_wait  output  1  high = access not finished
spi_cs_n  output  1  SRAM chip select, active-low
spi_sck  output  1  SPI clock, mode 0, idles low
spi_mosi  output  1  serial data to SRAM, MSB first
spi_miso  input  1  serial data from SRAM

Behaviour:
- Interface timing: one clock domain; reset is synchronous and active-high.
- Reset values: spi_cs_n=1, spi_sck=0, spi_mosi=0, bus_rdata=8'h00, state=IDLE, bit counter=0, divider=0.
- Reset taking effect mid-transaction: next cycle has cs_n=1 and sck=0; the transaction is abandoned and bus_rdata is cleared.
- bus_wait is combinational: (bus_read | bus_write) & (state != DONE). It is therefore high in the first cycle a request appears. The cpu samples bus_wait on the following edge, so this is mandatory.
- bus_rdata: registered. Changes only in FINISH of a read, or on reset. Writes leave it unchanged.

State machine:
- IDLE:
  - On request, latch address, wdata and direction into a 32-bit shift register: {opcode, addr[15:8], addr[7:0], data}. data = wdata for a write, 8'h00 for a read.
  - If bus_read & bus_write are both high, treat as a write.
  - Set cs_n=0, mosi=shift[31], go to START.
- START: 1 cycle of MOSI setup with sck low. Then go to SHIFT.
- SHIFT: 32 bits; each bit is SCK_HALF cycles low, then SCK_HALF cycles high.
  - End of low phase: sck<=1, sample miso into rx[0] (shifting rx left).
  - End of high phase: sck<=0, shift tx left, mosi<=next bit.
  - After the 32nd high phase, go to FINISH.
- FINISH: cs_n<=1, mosi<=0. On a read, bus_rdata <= rx[7:0] (the last 8 bits sampled). Go to DONE.
- DONE: bus_wait low. Stay while request is high; go to IDLE on the first cycle request is low.

Latency and request rules:
- Latency: with the request's first high cycle counted as 0, bus_wait is first low in cycle 64*SCK_HALF+3 (67 at default).
- The request must drop for ≥1 cycle between accesses; the cpu guarantees this.
- Address, data and direction changes after IDLE are ignored.
- Request dropped mid-transaction: the SPI transfer still completes. DONE then exits to IDLE immediately, and no bus_wait-low cycle is observed while the request is high.
- During a write, miso is ignored.
- cs_n stays low continuously from START through SHIFT, so every access is exactly one 32-bit frame.

Test Plan:
- Read 0x1234, SRAM model returns 0xA5 -> MOSI bytes 03,12,34,00; cs_n low for exactly one 32-SCK frame; bus_wait high cycles 0..66, low at 67; bus_rdata=0xA5 while in DONE.
- Write 0x5A to 0xBEEF -> MOSI bytes 02,BE,EF,5A; model memory[0xBEEF]=0x5A; bus_rdata keeps its prior value; bus_wait low at cycle 67.
- cpu-style sequence: write 0x77 to 0x0010, then read 0x0010 with 1 idle cycle between -> second frame starts the cycle after the idle cycle; read returns 0x77; no SCK edges while cs_n high.
- SCK_HALF=3: read 0x00FF -> each SCK level lasts 3 cycles; bus_wait low at cycle 195.
- rst asserted at the 10th SCK rising edge -> next cycle cs_n=1, sck=0, bus_rdata=0; a following read of 0x0001 completes normally in 67 cycles.
- bus_read dropped at cycle 20 of a read -> frame still completes (32 SCKs); state returns to IDLE within one cycle of DONE; bus_wait is 0 throughout since no request is present.
